// File: rtl/video_timing_rx.sv
// video_timing_rx: self-check monitor for the parallel pixel/sync bus.
// Measures the active resolution of each frame, declares lock after two
// consecutive identical error-free frames, and counts active pixels that
// differ from an expected solid colour.
// Optional build macro FRAME_CHECKSUM_EN adds frame_sum and hsync_cnt outputs.
// fsm_state_o exposes the internal state (0=IDLE, 1=MEASURE, 2=LOCKED).
// Handshake: none; the bus is sampled every clock with no back-pressure,
// and frame_done is a single-cycle strobe that qualifies all committed outputs.
module video_timing_rx #(
    parameter int TIMEOUT = 2000000,
    parameter int ERRW    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      red,
    input  logic [7:0]      green,
    input  logic [7:0]      blue,
    input  logic            hsync,
    input  logic            vsync,
    input  logic            ve,
    input  logic [23:0]     color,
    output logic [10:0]     hres_meas,
    output logic [9:0]      vres_meas,
    output logic            locked,
    output logic            frame_done,
    output logic            line_err,
    output logic [ERRW-1:0] color_err_cnt,
`ifdef FRAME_CHECKSUM_EN
    output logic [31:0]     frame_sum,
    output logic [10:0]     hsync_cnt,
`endif
    output logic [1:0]      fsm_state_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam int              WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

    logic [23:0]     s1_rgb_q;
    logic            s1_vs_q, s1_ve_q, s2_vs_q, s2_ve_q;
    logic [10:0]     px_q, len_q, acc_px, acc_len;
    logic [9:0]      line_q, acc_line;
    logic            err_q, acc_err;
    logic [ERRW-1:0] mis_q, acc_mis;
    logic [WDW-1:0]  wd_q;
    logic [1:0]      state_q, state_d;
    logic            locked_q, locked_d;
    logic [20:0]     prev_res_q;
    logic            prev_good_q;
    logic            vs_rise, ve_fall, good, same_res, commit, timeout;

    assign vs_rise  = s1_vs_q & ~s2_vs_q;
    assign ve_fall  = s2_ve_q & ~s1_ve_q;
    assign timeout  = (state_q != ST_IDLE) && !vs_rise && (wd_q == WD_LAST);
    assign commit   = vs_rise && (state_q != ST_IDLE);

    // Input stage S1 plus the second register used for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_rgb_q <= '0;
            s1_vs_q  <= 1'b0;
            s1_ve_q  <= 1'b0;
            s2_vs_q  <= 1'b0;
            s2_ve_q  <= 1'b0;
        end else begin
            s1_rgb_q <= {red, green, blue};
            s1_vs_q  <= vsync;
            s1_ve_q  <= ve;
            s2_vs_q  <= s1_vs_q;
            s2_ve_q  <= s1_ve_q;
        end
    end

    // Per-frame accumulation; a line ending on the frame edge is folded in
    always_comb begin
        acc_px   = px_q;
        acc_len  = len_q;
        acc_line = line_q;
        acc_err  = err_q;
        acc_mis  = mis_q;
        if (s1_ve_q) begin
            if (px_q == 11'h7FF) acc_err = 1'b1;
            else                 acc_px  = px_q + 11'd1;
            if (s1_rgb_q != color && mis_q != {ERRW{1'b1}}) acc_mis = mis_q + 1'b1;
        end
        if (ve_fall) begin
            if (line_q == 10'd0)     acc_len = px_q;
            else if (px_q != len_q)  acc_err = 1'b1;
            if (line_q == 10'h3FF)   acc_err  = 1'b1;
            else                     acc_line = line_q + 10'd1;
            acc_px = 11'd0;
        end
    end

    assign good     = !acc_err && (acc_line != 10'd0) && (acc_len != 11'd0);
    assign same_res = ({acc_len, acc_line} == prev_res_q);

    // Lock state machine; the watchdog overrides every state
    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE:    if (vs_rise) state_d = ST_MEASURE;
            ST_MEASURE: if (vs_rise && good && prev_good_q && same_res) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
            ST_LOCKED:  if (vs_rise && (!good || !same_res)) begin
                            state_d  = ST_MEASURE;
                            locked_d = 1'b0;
                        end
            default:    state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
        end
    end

    // Running counters, cleared at each frame boundary or on timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_q   <= '0;
            len_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            mis_q  <= '0;
        end else if (vs_rise || timeout) begin
            px_q   <= '0;
            len_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            mis_q  <= '0;
        end else begin
            px_q   <= acc_px;
            len_q  <= acc_len;
            line_q <= acc_line;
            err_q  <= acc_err;
            mis_q  <= acc_mis;
        end
    end

    // State, watchdog and committed frame results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            locked_q      <= 1'b0;
            wd_q          <= '0;
            frame_done    <= 1'b0;
            hres_meas     <= '0;
            vres_meas     <= '0;
            line_err      <= 1'b0;
            color_err_cnt <= '0;
            prev_res_q    <= '0;
            prev_good_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            frame_done <= commit;
            if (vs_rise || timeout)     wd_q <= '0;
            else if (state_q != ST_IDLE) wd_q <= wd_q + 1'b1;
            if (commit) begin
                hres_meas     <= acc_len;
                vres_meas     <= acc_line;
                line_err      <= acc_err;
                color_err_cnt <= acc_mis;
                prev_res_q    <= {acc_len, acc_line};
                prev_good_q   <= good;
            end else if (timeout) begin
                prev_good_q   <= 1'b0;
            end
        end
    end

    assign locked      = locked_q;
    assign fsm_state_o = state_q;

`ifdef FRAME_CHECKSUM_EN
    logic        s1_hs_q, s2_hs_q;
    logic [31:0] sum_q, acc_sum;
    logic [10:0] hsc_q, acc_hsc;

    assign acc_sum = s1_ve_q ? sum_q + {8'h00, s1_rgb_q} : sum_q;
    assign acc_hsc = (s1_hs_q && !s2_hs_q && hsc_q != 11'h7FF) ? hsc_q + 11'd1 : hsc_q;

    // Checksum and hsync edge count, committed alongside the frame results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_hs_q   <= 1'b0;
            s2_hs_q   <= 1'b0;
            sum_q     <= '0;
            hsc_q     <= '0;
            frame_sum <= '0;
            hsync_cnt <= '0;
        end else begin
            s1_hs_q <= hsync;
            s2_hs_q <= s1_hs_q;
            if (vs_rise || timeout) begin
                sum_q <= '0;
                hsc_q <= '0;
            end else begin
                sum_q <= acc_sum;
                hsc_q <= acc_hsc;
            end
            if (commit) begin
                frame_sum <= acc_sum;
                hsync_cnt <= acc_hsc;
            end
        end
    end
`else
    logic unused_hsync;
    assign unused_hsync = hsync;
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed bench for video_timing_rx using small frames
// (8x6 and 6x4 stand in for 800x600 and 640x480) and TIMEOUT=1000.
module tb_video_timing_rx;

    localparam int          ERRW = 16;
    localparam logic [23:0] C0   = 24'h112233;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      red = '0, green = '0, blue = '0;
    logic            hsync = 1'b0, vsync = 1'b0, ve = 1'b0;
    logic [23:0]     color = C0;
    logic [10:0]     hres_meas;
    logic [9:0]      vres_meas;
    logic            locked, frame_done, line_err;
    logic [ERRW-1:0] color_err_cnt;
    logic [1:0]      fsm_state;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0]     frame_sum;
    logic [10:0]     hsync_cnt;
`endif

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int done_cnt, done_idx;
    logic [31:0] cap_hres, cap_vres, cap_lock, cap_lerr, cap_cnt, cap_sum, cap_hsc;

    // Clock
    always #5 clock = ~clock;

    video_timing_rx #(.TIMEOUT(1000), .ERRW(ERRW)) dut (
        .clock(clock), .reset(reset),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .ve(ve), .color(color),
        .hres_meas(hres_meas), .vres_meas(vres_meas), .locked(locked),
        .frame_done(frame_done), .line_err(line_err), .color_err_cnt(color_err_cnt),
`ifdef FRAME_CHECKSUM_EN
        .frame_sum(frame_sum), .hsync_cnt(hsync_cnt),
`endif
        .fsm_state_o(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame body: v lines of h pixels, one line optionally short,
    // the first bad_px pixels of line 0 driven white
    task automatic body(input int h, input int v, input int short_line,
                        input int bad_px, input logic [23:0] pix);
        for (int l = 0; l < v; l++) begin
            for (int p = 0; p < ((l == short_line) ? h - 1 : h); p++) begin
                ve = 1'b1;
                {red, green, blue} = (l == 0 && p < bad_px) ? 24'hFFFFFF : pix;
                @(negedge clock);
            end
            ve = 1'b0;
            {red, green, blue} = 24'h0;
            hsync = 1'b1;
            @(negedge clock);
            hsync = 1'b0;
            repeat (2) @(negedge clock);
        end
        repeat (2) @(negedge clock);
    endtask

    // Vsync pulse; records every frame_done and the outputs at the first one
    task automatic vsync_pulse();
        done_cnt = 0;
        done_idx = 0;
        vsync = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (frame_done) begin
                done_cnt++;
                if (done_idx == 0) begin
                    done_idx = i;
                    cap_hres = 32'(hres_meas);
                    cap_vres = 32'(vres_meas);
                    cap_lock = 32'(locked);
                    cap_lerr = 32'(line_err);
                    cap_cnt  = 32'(color_err_cnt);
`ifdef FRAME_CHECKSUM_EN
                    cap_sum  = frame_sum;
                    cap_hsc  = 32'(hsync_cnt);
`endif
                end
            end
            if (i == 2) vsync = 1'b0;
        end
    endtask

    task automatic expect_commit(input string tag, input int h, input int v,
                                 input int lk, input int le, input int ce);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_lat"}, 32'(done_idx), 32'd2);
        check({tag, "_hres"}, cap_hres, 32'(h));
        check({tag, "_vres"}, cap_vres, 32'(v));
        check({tag, "_locked"}, cap_lock, 32'(lk));
        check({tag, "_line_err"}, cap_lerr, 32'(le));
        check({tag, "_color_err"}, cap_cnt, 32'(ce));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hres"}, 32'(hres_meas), 32'd0);
        check({tag, "_vres"}, 32'(vres_meas), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_line_err"}, 32'(line_err), 32'd0);
        check({tag, "_color_err"}, 32'(color_err_cnt), 32'd0);
        check({tag, "_fsm"}, 32'(fsm_state), 32'd0);
    endtask

    // Directed sequence
    initial begin
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge clock);

        body(8, 6, -1, 0, C0); vsync_pulse();
        check("partial_no_done", 32'(done_cnt), 32'd0);
        check("partial_fsm", 32'(fsm_state), 32'd1);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("f2", 8, 6, 0, 0, 0);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("f3", 8, 6, 1, 0, 0);
        check("f3_fsm", 32'(fsm_state), 32'd2);

        body(8, 6, 3, 0, C0);  vsync_pulse(); expect_commit("short", 8, 6, 0, 1, 0);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("relock1", 8, 6, 0, 0, 0);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("relock2", 8, 6, 1, 0, 0);

        body(8, 6, -1, 5, C0); vsync_pulse(); expect_commit("colour", 8, 6, 1, 0, 5);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("colour_clr", 8, 6, 1, 0, 0);

        body(6, 4, -1, 0, C0); vsync_pulse(); expect_commit("res_chg", 6, 4, 0, 0, 0);
        body(6, 4, -1, 0, C0); vsync_pulse(); expect_commit("res_lock", 6, 4, 1, 0, 0);

        // Watchdog: still locked one cycle before expiry, IDLE right after
        repeat (997) @(negedge clock);
        check("wd_before_locked", 32'(locked), 32'd1);
        check("wd_before_fsm", 32'(fsm_state), 32'd2);
        @(negedge clock);
        check("wd_locked", 32'(locked), 32'd0);
        check("wd_fsm", 32'(fsm_state), 32'd0);
        check("wd_hres_hold", 32'(hres_meas), 32'd6);
        check("wd_vres_hold", 32'(vres_meas), 32'd4);

        body(8, 6, -1, 0, C0); vsync_pulse();
        check("resume_partial", 32'(done_cnt), 32'd0);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("resume1", 8, 6, 0, 0, 0);
        body(8, 6, -1, 0, C0); vsync_pulse(); expect_commit("resume2", 8, 6, 1, 0, 0);

        // Asynchronous reset in the middle of a frame
        body(8, 2, -1, 0, C0);
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b1;
        body(8, 6, -1, 0, C0); vsync_pulse();
        check("rst_partial", 32'(done_cnt), 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'd1);

        color = 24'h000001;
        body(4, 2, -1, 0, 24'h000001); vsync_pulse(); expect_commit("small", 4, 2, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        check("frame_sum", cap_sum, 32'd8);
        check("hsync_cnt", cap_hsc, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
